ysyx_23060332_wb_arb: RTL and testbench

Write-back arbiter and register scoreboard for the single-write-port register file. It shares the one write port between EXU (ALU results) and LSU (load data) with round-robin valid/ready arbitration and registers the winning write onto `waddr`/`wdata`/`reg_wen`. It tracks destination registers with pending writes and tells IDU when to stall on RAW or WAW hazards. It sits between IDU/EXU/LSU and `ysyx_23060332_reg`.

---
 rtl/ysyx_23060332_wb_arb_pkg.sv | 18 +
 rtl/ysyx_23060332_wb_arb_sb.sv | 68 ++++++
 rtl/ysyx_23060332_wb_arb.sv | 113 +++++++++++
 tb/tb_ysyx_23060332_wb_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_wb_arb_pkg.sv
// Shared widths and grant encodings for the write-back arbiter and its
// register scoreboard.
//   RegAddrBus : register index width (5)
//   RegDataBus : register data width (32)
//   RegNum     : number of architectural registers (32)
//   gnt_e      : which requester won the last write-port transfer
package ysyx_23060332_wb_arb_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;
    localparam int RegNum     = 32;

    typedef enum logic {
        GntExu = 1'b0,
        GntLsu = 1'b1
    } gnt_e;

endpackage

// File: rtl/ysyx_23060332_wb_arb_sb.sv
// Register scoreboard: one busy bit per architectural register.
//   clk, rst          : clock, synchronous active-low reset
//   set_en_i/idx_i    : mark a destination as pending (issue accepted)
//   clr_en_i/idx_i    : clear a pending destination (write committed)
//   issue_*_i         : instruction presented by IDU, for the hazard compare
//   stall_o           : RAW/WAW hazard against the registered busy bits
//   busy_vec_o        : busy bits, bit 0 held at 0
//   sb_err_o          : sticky, a commit hit a register that was not busy
module ysyx_23060332_sb
    import ysyx_23060332_wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [RegAddrBus-1:0] set_idx_i,
    input  logic                  clr_en_i,
    input  logic [RegAddrBus-1:0] clr_idx_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_wen_i,
    input  logic [RegAddrBus-1:0] issue_rd_i,
    input  logic [RegAddrBus-1:0] issue_rs1_i,
    input  logic [RegAddrBus-1:0] issue_rs2_i,
    input  logic                  issue_use_rs1_i,
    input  logic                  issue_use_rs2_i,
    output logic                  stall_o,
    output logic [RegNum-1:0]     busy_vec_o,
    output logic                  sb_err_o
);

    logic [RegNum-1:0] busy_q, busy_d;
    logic              err_q, err_d;
    logic              set_same_idx;

    // A simultaneous set of the committing index counts as a new pending
    // write, so the commit is not treated as spurious.
    assign set_same_idx = set_en_i && (set_idx_i == clr_idx_i) && (set_idx_i != '0);

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && (set_idx_i != '0)) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q | (clr_en_i & ~busy_q[clr_idx_i] & ~set_same_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign stall_o = issue_valid_i & ((issue_use_rs1_i & busy_q[issue_rs1_i]) |
                                      (issue_use_rs2_i & busy_q[issue_rs2_i]) |
                                      (issue_wen_i     & busy_q[issue_rd_i]));

    assign busy_vec_o = busy_q;
    assign sb_err_o   = err_q;

endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// Write-back arbiter: shares the single regfile write port between EXU and
// LSU with round-robin valid/ready, registers the winning write, and keeps a
// scoreboard of pending destinations to stall IDU on RAW/WAW hazards.
//   clk, rst             : clock, synchronous active-low reset
//   issue_*              : IDU instruction (valid, wen, rd, rs1/rs2 and use)
//   stall                : IDU must hold the instruction (combinational)
//   exu_valid/rd/data    : EXU result request; exu_ready grant
//   lsu_valid/rd/data    : LSU result request; lsu_ready grant
//   waddr/wdata/reg_wen  : registered write to the regfile
//   busy_vec             : pending-write bits
//   sb_err               : sticky, a commit hit a non-busy register
module ysyx_23060332_wb_arb
    import ysyx_23060332_wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [RegAddrBus-1:0] issue_rd,
    input  logic [RegAddrBus-1:0] issue_rs1,
    input  logic [RegAddrBus-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    output logic                  stall,
    input  logic                  exu_valid,
    input  logic [RegAddrBus-1:0] exu_rd,
    input  logic [RegDataBus-1:0] exu_data,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [RegAddrBus-1:0] lsu_rd,
    input  logic [RegDataBus-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegDataBus-1:0] wdata,
    output logic                  reg_wen,
    output logic [RegNum-1:0]     busy_vec,
    output logic                  sb_err
);

    gnt_e                  last_grant_q, last_grant_d;
    logic [RegAddrBus-1:0] waddr_q, waddr_d;
    logic [RegDataBus-1:0] wdata_q, wdata_d;
    logic                  reg_wen_q, reg_wen_d;
    logic                  sb_stall;
    logic                  exu_acc, lsu_acc;
    logic                  issue_set;

    // Under contention the requester that did not win last time goes first.
    assign exu_ready = rst & exu_valid & (~lsu_valid | (last_grant_q == GntLsu));
    assign lsu_ready = rst & lsu_valid & (~exu_valid | (last_grant_q == GntExu));
    assign stall     = rst & sb_stall;

    assign exu_acc   = exu_valid & exu_ready;
    assign lsu_acc   = lsu_valid & lsu_ready;
    assign issue_set = issue_valid & ~stall & issue_wen;

    always_comb begin
        last_grant_d = last_grant_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        reg_wen_d    = 1'b0;
        if (exu_acc) begin
            last_grant_d = GntExu;
            waddr_d      = exu_rd;
            wdata_d      = exu_data;
            reg_wen_d    = (exu_rd != '0);
        end else if (lsu_acc) begin
            last_grant_d = GntLsu;
            waddr_d      = lsu_rd;
            wdata_d      = lsu_data;
            reg_wen_d    = (lsu_rd != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= GntExu;
            waddr_q      <= '0;
            wdata_q      <= '0;
            reg_wen_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            reg_wen_q    <= reg_wen_d;
        end
    end

    // The regfile write lands at the same edge that retires the busy bit.
    ysyx_23060332_sb u_sb (
        .clk             (clk),
        .rst             (rst),
        .set_en_i        (issue_set),
        .set_idx_i       (issue_rd),
        .clr_en_i        (reg_wen_q),
        .clr_idx_i       (waddr_q),
        .issue_valid_i   (issue_valid),
        .issue_wen_i     (issue_wen),
        .issue_rd_i      (issue_rd),
        .issue_rs1_i     (issue_rs1),
        .issue_rs2_i     (issue_rs2),
        .issue_use_rs1_i (issue_use_rs1),
        .issue_use_rs2_i (issue_use_rs2),
        .stall_o         (sb_stall),
        .busy_vec_o      (busy_vec),
        .sb_err_o        (sb_err)
    );

    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign reg_wen = reg_wen_q;

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
module tb_ysyx_23060332_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wen, issue_use_rs1, issue_use_rs2;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        stall;
    logic        exu_valid, lsu_valid;
    logic [4:0]  exu_rd, lsu_rd;
    logic [31:0] exu_data, lsu_data;
    logic        exu_ready, lsu_ready;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_wen;
    logic [31:0] busy_vec;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    ysyx_23060332_wb_arb dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_wen     (issue_wen),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .stall         (stall),
        .exu_valid     (exu_valid),
        .exu_rd        (exu_rd),
        .exu_data      (exu_data),
        .exu_ready     (exu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .waddr         (waddr),
        .wdata         (wdata),
        .reg_wen       (reg_wen),
        .busy_vec      (busy_vec),
        .sb_err        (sb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        issue_rs1 = '0; issue_rs2 = '0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        step(); step();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want %h", busy_vec, 32'h0); end
        checks++; if (reg_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", reg_wen); end
        checks++; if (waddr !== 5'd0 || wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %0d/%h want 0/0", waddr, wdata); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", sb_err); end
        exu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1;
        #1;
        checks++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", exu_ready, lsu_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        exu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic test_issue();
        rst = 1'b1;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd5;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_nostall got %b want 0", stall); end
        step();
        issue_wen = 1'b0; issue_use_rs1 = 1'b1; issue_rs1 = 5'd5;
        #1;
        checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL issue_busy got %h want %h", busy_vec, 32'h20); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_rs1 got %b want 1", stall); end
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b1; issue_rs2 = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_rs2 got %b want 1", stall); end
        issue_use_rs2 = 1'b0; issue_wen = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw got %b want 1", stall); end
        issue_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_novalid got %b want 0", stall); end
        issue_valid = 1'b1; issue_wen = 1'b0; issue_use_rs1 = 1'b1; issue_rs1 = 5'd5;
    endtask

    task automatic test_commit();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
        #1;
        checks++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL commit_ready got %b%b want 10", exu_ready, lsu_ready); end
        step();
        exu_valid = 1'b0;
        #1;
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin errors++; $display("FAIL commit_write got %b/%0d/%h want 1/5/1234", reg_wen, waddr, wdata); end
        checks++; if (busy_vec !== 32'h20 || stall !== 1'b1) begin errors++; $display("FAIL commit_nobypass got %h/%b want 20/1", busy_vec, stall); end
        step();
        checks++; if (busy_vec !== 32'h0 || stall !== 1'b0 || reg_wen !== 1'b0) begin errors++; $display("FAIL commit_clear got %h/%b/%b want 0/0/0", busy_vec, stall, reg_wen); end
        issue_valid = 1'b0; issue_use_rs1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] rds [4] = '{5'd3, 5'd4, 5'd7, 5'd8};
        issue_valid = 1'b1; issue_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_rd = rds[i];
            step();
        end
        issue_valid = 1'b0; issue_wen = 1'b0;
        #1;
        checks++; if (busy_vec !== 32'h198) begin errors++; $display("FAIL b2b_busy got %h want %h", busy_vec, 32'h198); end
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAAAA0003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB0004;
        #1;
        checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin errors++; $display("FAIL rr_g0 got e%b l%b want e0 l1", exu_ready, lsu_ready); end
        step();
        lsu_rd = 5'd7; lsu_data = 32'hBBBB0007;
        #1;
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd4 || wdata !== 32'hBBBB0004) begin errors++; $display("FAIL rr_w0 got %b/%0d/%h want 1/4/bbbb0004", reg_wen, waddr, wdata); end
        checks++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL rr_g1 got e%b l%b want e1 l0", exu_ready, lsu_ready); end
        step();
        exu_rd = 5'd8; exu_data = 32'hAAAA0008;
        #1;
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAAAA0003) begin errors++; $display("FAIL rr_w1 got %b/%0d/%h want 1/3/aaaa0003", reg_wen, waddr, wdata); end
        checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin errors++; $display("FAIL rr_g2 got e%b l%b want e0 l1", exu_ready, lsu_ready); end
        step();
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hBBBB0007) begin errors++; $display("FAIL rr_w2 got %b/%0d/%h want 1/7/bbbb0007", reg_wen, waddr, wdata); end
        checks++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL rr_g3 got e%b l%b want e1 l0", exu_ready, lsu_ready); end
        step();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd8 || wdata !== 32'hAAAA0008) begin errors++; $display("FAIL rr_w3 got %b/%0d/%h want 1/8/aaaa0008", reg_wen, waddr, wdata); end
        step();
        checks++; if (reg_wen !== 1'b0 || busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL rr_end got %b/%h/%b want 0/0/0", reg_wen, busy_vec, sb_err); end
    endtask

    task automatic test_x0();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD0000;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", lsu_ready); end
        step();
        lsu_valid = 1'b0;
        #1;
        checks++; if (reg_wen !== 1'b0 || busy_vec !== 32'h0) begin errors++; $display("FAIL x0_wen got %b/%h want 0/0", reg_wen, busy_vec); end
        exu_valid = 1'b1; exu_rd = 5'd0; lsu_valid = 1'b1; lsu_rd = 5'd0;
        #1;
        checks++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL x0_lastgrant got e%b l%b want e1 l0", exu_ready, lsu_ready); end
        step();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        checks++; if (reg_wen !== 1'b0 || sb_err !== 1'b0 || busy_vec !== 32'h0) begin errors++; $display("FAIL x0_end got %b/%b/%h want 0/0/0", reg_wen, sb_err, busy_vec); end
    endtask

    task automatic test_sb_err();
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
        #1;
        checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", exu_ready); end
        step();
        exu_valid = 1'b0;
        #1;
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd9 || sb_err !== 1'b0) begin errors++; $display("FAIL err_pre got %b/%0d/%b want 1/9/0", reg_wen, waddr, sb_err); end
        step();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sb_err); end
        step(); step(); step();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_err); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd10;
        step();
        issue_valid = 1'b0; issue_wen = 1'b0;
        #1;
        checks++; if (busy_vec !== 32'h400) begin errors++; $display("FAIL mid_busy got %h want %h", busy_vec, 32'h400); end
        exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hCAFE;
        step();
        checks++; if (reg_wen !== 1'b1 || waddr !== 5'd10) begin errors++; $display("FAIL mid_wen got %b/%0d want 1/10", reg_wen, waddr); end
        rst = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd12;
        issue_valid = 1'b1; issue_use_rs1 = 1'b1; issue_rs1 = 5'd10;
        #1;
        checks++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mid_gate got e%b l%b s%b want 000", exu_ready, lsu_ready, stall); end
        step();
        checks++; if (reg_wen !== 1'b0 || busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL mid_reset got %b/%h/%b want 0/0/0", reg_wen, busy_vec, sb_err); end
        checks++; if (waddr !== 5'd0 || wdata !== 32'h0) begin errors++; $display("FAIL mid_regs got %0d/%h want 0/0", waddr, wdata); end
        rst = 1'b1;
        issue_valid = 1'b0; issue_use_rs1 = 1'b0;
        #1;
        checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin errors++; $display("FAIL mid_lastgrant got e%b l%b want e0 l1", exu_ready, lsu_ready); end
        exu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_set_clear_same();
        exu_valid = 1'b1; exu_rd = 5'd11; exu_data = 32'h11;
        step();
        exu_valid = 1'b0;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd11;
        #1;
        checks++; if (stall !== 1'b0 || reg_wen !== 1'b1) begin errors++; $display("FAIL sc_pre got %b/%b want 0/1", stall, reg_wen); end
        step();
        issue_valid = 1'b0; issue_wen = 1'b0;
        #1;
        checks++; if (busy_vec !== 32'h800 || sb_err !== 1'b0) begin errors++; $display("FAIL sc_setwins got %h/%b want 800/0", busy_vec, sb_err); end
        exu_valid = 1'b1;
        step();
        exu_valid = 1'b0;
        step();
        checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) begin errors++; $display("FAIL sc_end got %h/%b want 0/0", busy_vec, sb_err); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_commit();
        test_back_to_back();
        test_x0();
        test_sb_err();
        test_reset_mid();
        test_set_clear_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
